approx_or_adder_pipe: RTL
=========================

APPROX_OR_ADDER_PIPE -- requirements
Module: approx_or_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (at least 2).
REQ-002 SHALL have parameter MAX_APPROX, default 4, meaning the largest number of low bits that may be approximated (0 to WIDTH-1).
REQ-003 SHALL have parameter ACC_W, default 24, meaning the width of the error and transaction accumulators.
REQ-004 SHALL have ports, one per line, as name / direction / width / meaning:
- clk / in / 1 / the single clock; all state on its rising edge.
- rst_n / in / 1 / reset; synchronous, active-low.
- in_valid / in / 1 / input operands valid.
- in_ready / out / 1 / input stage can accept.
- a / in / WIDTH / operand A.
- b / in / WIDTH / operand B.
- cin / in / 1 / carry in; used only when the effective k is 0.
- approx_k / in / clog2(WIDTH+1) / requested approximate low-bit count.
- out_valid / out / 1 / result valid.
- out_ready / in / 1 / downstream accepts.
- sum / out / WIDTH / approximate sum.
- cout / out / 1 / approximate carry out.
- err / out / WIDTH+1 / absolute error against the exact sum.
- stats_clr / in / 1 / clear the accumulators.
- err_acc / out / ACC_W / saturating sum of err over accepted results.
- txn_cnt / out / ACC_W / saturating count of accepted results.

Function
REQ-005 SHALL compute the effective k as min(approx_k, MAX_APPROX); approx_k is sampled together with the operands.
REQ-006 SHALL form the low k bits of sum as the bitwise OR a|b and SHALL ignore cin when k>0.
REQ-007 SHALL form the upper WIDTH-k bits as the exact sum of those bits of a and b.
- Carry-in to the upper part: a[k-1]&b[k-1] when k>0; cin when k=0.
- cout is the carry out of bit WIDTH-1.
REQ-008 SHALL compute err as |(a+b+cin) - {cout,sum}| at WIDTH+1 bits; k=0 SHALL always give err=0.
REQ-009 SHALL use two register stages:
- S1 holds a, b, cin and k.
- S2 holds sum, cout and err.
- Latency from input handshake (in_valid&in_ready) to out_valid is exactly 2 cycles when unstalled.
REQ-010 SHALL sustain one result per cycle while out_ready=1.
REQ-011 SHALL stall each stage only when it is full and cannot advance:
- in_ready = !S1_valid || S1 advances this cycle.
- S1 advances when !S2_valid || out_ready.
REQ-012 SHALL hold sum, cout and err stable while out_valid=1 and out_ready=0.
REQ-013 SHALL not depend on in_valid being held; no result is ever lost or duplicated under any ready/valid pattern.
REQ-014 SHALL update the accumulators on each output handshake (out_valid&out_ready):
- txn_cnt += 1 and err_acc += err.
- Each saturates at all-ones and does not wrap.
REQ-015 SHALL, when stats_clr coincides with an output handshake, clear first and then count that result (txn_cnt=1, err_acc=err).
REQ-016 SHALL not affect the datapath or handshakes when stats_clr is asserted.

Reset
REQ-017 SHALL, while rst_n=0 at a clock edge, clear S1_valid, S2_valid, sum, cout, err, err_acc and txn_cnt to 0, and drive in_ready=1 from the cycle after reset.
REQ-018 SHALL discard any in-flight operations on reset mid-operation and produce no spurious out_valid after reset releases.

Structure
REQ-019 SHALL place the shared approximate-adder constants and the k-saturation function in package approx_add_pkg.
REQ-020 SHALL implement the combinational adder as sub-module approx_or_adder_core, parameterised by WIDTH, taking k as an input, and instantiated between S1 and S2.

Verification (WIDTH=8, MAX_APPROX=4)
REQ-021 SHALL check these directed scenarios:
- a=0x0F, b=0x01, k=0, cin=0 -> sum=0x10, cout=0, err=0, out_valid exactly 2 cycles after input.
- a=0x0F, b=0x01, k=4 -> sum=0x0F, err=1; same operands with approx_k=8 -> identical result (saturated to 4).
- a=0x88, b=0x88, k=4 -> sum=0x18, cout=1, err=8; a=0xFF, b=0x01, k=2 -> sum=0xFF, cout=0, err=1.
- Back-to-back stream of 10 inputs with out_ready low for cycles 3-6 -> in_ready drops once both stages are full, outputs stay stable, all 10 results arrive in order, txn_cnt=10.
- stats_clr together with a handshake where err=8 -> txn_cnt=1, err_acc=8; err_acc preloaded near all-ones -> saturates, no wrap.
- rst_n low for 1 cycle with both stages full -> out_valid=0, accumulators 0, next accepted input appears 2 cycles later.

Source files
------------

// File: rtl/approx_add_pkg.sv
// Shared constants and helpers for the approximate OR-based adder pipeline.
package approx_add_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_MAX_APPROX = 4;
    localparam int DEF_ACC_W      = 24;

    // Clamp the requested approximate low-bit count to what the instance supports.
    function automatic int unsigned sat_k(input int unsigned k_req, input int unsigned k_max);
        return (k_req > k_max) ? k_max : k_req;
    endfunction

endpackage

// File: rtl/approx_or_adder_pipe_if.sv
// Operand/result handshake bundle for approx_or_adder_pipe.
interface approx_or_adder_pipe_if
    import approx_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    localparam int KW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [KW-1:0]    approx_k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH:0]   err;

    modport master (
        output in_valid, a, b, cin, approx_k, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, a, b, cin, approx_k, out_ready,
        output in_ready, out_valid, sum, cout, err
    );
endinterface

// File: rtl/approx_or_adder_core.sv
// Combinational approximate adder: OR on the low k bits, exact add above,
// plus the absolute error against the exact sum.
module approx_or_adder_core
    import approx_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   err
);
    logic [WIDTH:0] ea, eb, exact, approx, mask, upper, carry_vec;
    logic           c_up;

    always_comb begin
        ea        = {1'b0, a};
        eb        = {1'b0, b};
        exact     = ea + eb + {{WIDTH{1'b0}}, cin};
        approx    = exact;
        mask      = '0;
        upper     = '0;
        carry_vec = '0;
        c_up      = 1'b0;
        if (k != '0) begin
            // The upper part is seeded with the generate of the top approximated bit.
            mask      = ({{WIDTH{1'b0}}, 1'b1} << k) - {{WIDTH{1'b0}}, 1'b1};
            carry_vec = (ea & eb) >> (k - KW'(1));
            c_up      = carry_vec[0];
            upper     = (ea >> k) + (eb >> k) + {{WIDTH{1'b0}}, c_up};
            approx    = (upper << k) | ((ea | eb) & mask);
        end
        sum  = approx[WIDTH-1:0];
        cout = approx[WIDTH];
        err  = (exact >= approx) ? (exact - approx) : (approx - exact);
    end
endmodule

// File: rtl/approx_or_adder_pipe.sv
// Two-stage ready/valid pipeline around approx_or_adder_core with saturating
// error and transaction accumulators.
module approx_or_adder_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MAX_APPROX = DEF_MAX_APPROX,
    parameter int ACC_W      = DEF_ACC_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         cin,
    input  logic [$clog2(WIDTH+1)-1:0]   approx_k,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             sum,
    output logic                         cout,
    output logic [WIDTH:0]               err,
    input  logic                         stats_clr,
    output logic [ACC_W-1:0]             err_acc,
    output logic [ACC_W-1:0]             txn_cnt
);
    localparam int KW = $clog2(WIDTH + 1);

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [ACC_W-1:0] inc);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    logic             vld_p1_q, vld_p2_q;
    logic [WIDTH-1:0] a_p1_q, b_p1_q;
    logic             cin_p1_q;
    logic [KW-1:0]    k_p1_q, k_p1_d;
    logic [WIDTH-1:0] sum_p2_q, sum_p2_d;
    logic             cout_p2_q, cout_p2_d;
    logic [WIDTH:0]   err_p2_q, err_p2_d;
    logic [ACC_W-1:0] err_acc_q, err_acc_d, txn_cnt_q, txn_cnt_d;
    logic             adv_p2, out_hs;

    assign adv_p2   = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || adv_p2;
    assign out_hs   = vld_p2_q && out_ready;
    assign k_p1_d   = KW'(sat_k(32'(approx_k), MAX_APPROX));

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else if (in_ready) begin
            vld_p1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_p1_q   <= a;
            b_p1_q   <= b;
            cin_p1_q <= cin;
            k_p1_q   <= k_p1_d;
        end
    end

    approx_or_adder_core #(.WIDTH(WIDTH), .KW(KW)) u_core (
        .a   (a_p1_q),
        .b   (b_p1_q),
        .cin (cin_p1_q),
        .k   (k_p1_q),
        .sum (sum_p2_d),
        .cout(cout_p2_d),
        .err (err_p2_d)
    );

    // Stage 2: result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            sum_p2_q  <= '0;
            cout_p2_q <= 1'b0;
            err_p2_q  <= '0;
        end else if (adv_p2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                sum_p2_q  <= sum_p2_d;
                cout_p2_q <= cout_p2_d;
                err_p2_q  <= err_p2_d;
            end
        end
    end

    // A clear coinciding with a handshake still counts that result.
    always_comb begin
        err_acc_d = stats_clr ? '0 : err_acc_q;
        txn_cnt_d = stats_clr ? '0 : txn_cnt_q;
        if (out_hs) begin
            err_acc_d = sat_add(err_acc_d, ACC_W'(err_p2_q));
            txn_cnt_d = sat_add(txn_cnt_d, ACC_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_acc_q <= '0;
            txn_cnt_q <= '0;
        end else begin
            err_acc_q <= err_acc_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign sum       = sum_p2_q;
    assign cout      = cout_p2_q;
    assign err       = err_p2_q;
    assign err_acc   = err_acc_q;
    assign txn_cnt   = txn_cnt_q;
endmodule
